// File: rtl/text_disp_pkg.sv
// text_disp_pkg: shared geometry constants and pipeline stage records for the text display read path.
package text_disp_pkg;
  localparam int CELL_W = 8;
  localparam int CELL_H = 8;
  localparam int FETCH_LATENCY = 3;
  localparam int GLYPH_W = 7;
  localparam int INV_BIT = 7;
  localparam int FONT_ADDR_W = 10;
  typedef struct packed {
    logic       vis;
    logic [2:0] bx;
    logic [2:0] by;
    logic       cur;
    logic       hs;
    logic       vs;
  } s1_t;
  typedef struct packed {
    logic       vis;
    logic [2:0] bx;
    logic       cur;
    logic       inv;
    logic       hs;
    logic       vs;
  } s2_t;
endpackage

// File: rtl/cursor_blink.sv
// cursor_blink: counts vsync rising edges and toggles the blink phase every BLINK_FRAMES frames.
module cursor_blink #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync_in,
  output logic blink
);
  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
  logic             vs_q, blink_q;
  logic [CNT_W-1:0] cnt_q;
  logic             frame, wrap;
  assign frame = vsync_in & ~vs_q;
  assign wrap  = cnt_q == CNT_W'(BLINK_FRAMES - 1);
  assign blink = blink_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vs_q    <= 1'b0;
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      vs_q <= vsync_in;
      if (frame) begin
        cnt_q   <= wrap ? '0 : cnt_q + CNT_W'(1);
        blink_q <= blink_q ^ wrap;
      end
    end
endmodule

// File: rtl/text_pixel_fetch.sv
// text_pixel_fetch: 3-stage beam-position -> char RAM -> font ROM -> pixel pipeline with
// inverse video, blinking cursor, off-screen blanking and matching sync delay.
module text_pixel_fetch
  import text_disp_pkg::*;
#(
  parameter int COLS         = 32,
  parameter int ROWS         = 30,
  parameter int ADDR_W       = 14,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8:0]             hpos,
  input  logic [8:0]             vpos,
  input  logic                   display_on,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   cursor_en,
  input  logic [5:0]             cursor_col,
  input  logic [4:0]             cursor_row,
  output logic [ADDR_W-1:0]      ram_addr,
  input  logic [7:0]             ram_dout,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             font_bits,
  output logic                   pixel,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   blink
);
  s1_t        s1_q;
  s2_t        s2_q;
  logic       pixel_q, hs_q, vs_q;
  logic [5:0] col, row;
  logic       vis0, cur0, pix_d;
  assign col  = hpos[8:3];
  assign row  = vpos[8:3];
  assign vis0 = display_on && 32'(col) < COLS && 32'(row) < ROWS;
  // cursor_row is zero-extended so rows >= 32 can never alias onto a valid cursor
  assign cur0 = cursor_en && col == cursor_col && row == {1'b0, cursor_row};
  assign ram_addr  = vis0 ? ADDR_W'(32'(row) * COLS + 32'(col)) : '0;
  assign font_addr = {ram_dout[GLYPH_W-1:0], s1_q.by};
  assign pix_d = s2_q.vis & (font_bits[3'(CELL_W - 1) - s2_q.bx] ^ s2_q.inv ^ (s2_q.cur & blink));
  assign pixel     = pixel_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  cursor_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk      (clk),
    .reset_n  (reset_n),
    .vsync_in (vsync_in),
    .blink    (blink)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pixel_q <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      s1_q    <= '{vis: vis0, bx: hpos[2:0], by: vpos[2:0], cur: cur0, hs: hsync_in, vs: vsync_in};
      s2_q    <= '{vis: s1_q.vis, bx: s1_q.bx, cur: s1_q.cur, inv: ram_dout[INV_BIT], hs: s1_q.hs, vs: s1_q.vs};
      pixel_q <= pix_d;
      hs_q    <= s2_q.hs;
      vs_q    <= s2_q.vs;
    end
endmodule

// File: tb/tb_text_pixel_fetch.sv
// tb_text_pixel_fetch: directed and randomized checks of text_pixel_fetch against a
// cell/glyph-level reference model with 1-cycle char RAM and font ROM models.
module tb_text_pixel_fetch;
  localparam int COLS = 32, ROWS = 30, ADDR_W = 14, BF = 2;
  logic              clk, reset_n, display_on, hsync_in, vsync_in, cursor_en;
  logic [8:0]        hpos, vpos;
  logic [5:0]        cursor_col;
  logic [4:0]        cursor_row;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout, font_bits;
  logic [9:0]        font_addr;
  logic              pixel, hsync_out, vsync_out, blink;

  text_pixel_fetch #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .font_addr(font_addr), .font_bits(font_bits),
    .pixel(pixel), .hsync_out(hsync_out), .vsync_out(vsync_out), .blink(blink)
  );

  logic [7:0] mem [0:16383];
  logic [7:0] font [0:1023];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    ram_dout  <= mem[ram_addr];
    font_bits <= font[font_addr];
  end

  typedef struct {
    bit         vis;
    bit         cur;
    bit         pnb;
    bit         hs;
    bit         vs;
    logic [9:0] fa;
  } ent_t;
  ent_t hist [0:8191];
  bit   bd   [0:8191];
  bit   obs  [0:8191];
  int   cyc, valid_from, n_cmp, n_bad;
  bit   mb, mprev;
  int   mcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One pixel clock: called at a falling edge with inputs already driven.
  task automatic step();
    ent_t e;
    int col, row, a;
    bit vis, ep, ehs, evs;
    logic [7:0] c, f;
    #1;
    ep = 0; ehs = 0; evs = 0;
    if (cyc - 3 >= valid_from) begin
      e   = hist[cyc-3];
      ep  = e.vis && (e.pnb ^ (e.cur && bd[cyc-1]));
      ehs = e.hs;
      evs = e.vs;
    end
    check("pixel", pixel, ep);
    check("hsync_out", hsync_out, ehs);
    check("vsync_out", vsync_out, evs);
    check("blink", blink, mb);
    obs[cyc] = pixel;
    if (cyc - 1 >= valid_from) check("font_addr", font_addr, hist[cyc-1].fa);
    col = int'(hpos) / 8;
    row = int'(vpos) / 8;
    vis = display_on && col < COLS && row < ROWS;
    a   = vis ? row * COLS + col : 0;
    check("ram_addr", ram_addr, a);
    c = mem[a];
    f = font[{c[6:0], vpos[2:0]}];
    e.vis = vis;
    e.cur = cursor_en && int'(cursor_col) == col && int'(cursor_row) == row;
    e.pnb = f[7 - int'(hpos[2:0])] ^ c[7];
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.fa  = {c[6:0], vpos[2:0]};
    hist[cyc] = e;
    bd[cyc]   = mb;
    if (vsync_in && !mprev) begin
      if (mcnt == BF - 1) begin
        mcnt = 0;
        mb   = ~mb;
      end else mcnt++;
    end
    mprev = vsync_in;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    display_on = 0;
    repeat (n) begin
      hpos = 9'($urandom_range(0, 511));
      step();
    end
  endtask

  function automatic logic [7:0] obs_byte(input int s);
    logic [7:0] b = 0;
    for (int i = 0; i < 8; i++) b = {b[6:0], obs[s+3+i]};
    return b;
  endfunction

  initial begin
    int s1, s2, s3;
    logic [3:0] bexp;
    clk = 0; reset_n = 0; display_on = 0; hsync_in = 0; vsync_in = 0; cursor_en = 0;
    hpos = 0; vpos = 0; cursor_col = 0; cursor_row = 0;
    n_cmp = 0; n_bad = 0; cyc = 0; valid_from = 0; mb = 0; mprev = 0; mcnt = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) font[i] = 8'($urandom);
    mem[0] = 8'h41; mem[34] = 8'hC1; font[10'h208] = 8'h18;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pixel", pixel, 0);
    check("rst_hsync", hsync_out, 0);
    check("rst_vsync", vsync_out, 0);
    check("rst_blink", blink, 0);
    @(negedge clk);
    reset_n = 1;
    // Glyph row, normal video
    s1 = cyc; vpos = 0; display_on = 1;
    for (int h = 0; h < 8; h++) begin hpos = 9'(h); step(); end
    idle(3);
    check("t1_pixels", obs_byte(s1), 8'h18);
    // Inverse-video character in cell (2,1)
    s2 = cyc; vpos = 8; display_on = 1; hpos = 16;
    #1 check("t2_ram_addr", ram_addr, 34);
    for (int h = 16; h < 24; h++) begin hpos = 9'(h); step(); end
    idle(3);
    check("t2_pixels", obs_byte(s2), 8'hE7);
    // Cursor blink on the inverse cell; cursor cancels inverse while blink=1
    cursor_en = 1; cursor_col = 2; cursor_row = 1; vpos = 8; display_on = 1;
    bexp = 4'b0110; s3 = 0;
    for (int p = 0; p < 4; p++) begin
      vsync_in = 1;
      for (int h = 16; h < 24; h++) begin hpos = 9'(h); step(); end
      vsync_in = 0;
      if (p == 1) s3 = cyc;
      for (int h = 16; h < 24; h++) begin hpos = 9'(h); step(); end
      check("t3_blink_phase", blink, bexp[p]);
    end
    check("t3_cursor_pixels", obs_byte(s3), 8'h18);
    cursor_en = 0;
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 16 == 0) begin
        cursor_en  = $urandom_range(0, 3) != 0;
        cursor_col = 6'($urandom_range(0, 40));
        cursor_row = 5'($urandom_range(0, 31));
      end
      display_on = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 1) == 1) begin
        hpos = 9'(int'(cursor_col) * 8 + $urandom_range(0, 7));
        vpos = 9'(int'(cursor_row) * 8 + $urandom_range(0, 7));
      end else begin
        hpos = 9'($urandom_range(0, 300));
        vpos = 9'($urandom_range(0, 260));
      end
      hsync_in = 1'($urandom);
      vsync_in = $urandom_range(0, 3) == 0;
      step();
    end
    cursor_en = 0; vsync_in = 0; hsync_in = 0;
    idle(3);
    // Off-screen blanking with every character bit set
    for (int i = 0; i < 16384; i++) mem[i] = 8'hFF;
    for (int i = 0; i < 8; i++) font[10'h3F8 + i] = 8'h00;
    display_on = 1; hpos = 256; vpos = 8;
    #1 check("t4_offcol_addr", ram_addr, 0);
    repeat (4) step();
    check("t4_offcol_pixel", pixel, 0);
    display_on = 0; hpos = 0; vpos = 0;
    repeat (4) step();
    check("t4_blank_pixel", pixel, 0);
    display_on = 1; hpos = 248; vpos = 232;
    #1 check("last_cell_addr", ram_addr, 959);
    repeat (4) step();
    check("last_cell_pixel", pixel, 1);
    // Asynchronous reset mid-line while driving a lit pixel
    hpos = 0; vpos = 0; hsync_in = 1; vsync_in = 1;
    repeat (4) step();
    check("pre_rst_pixel", pixel, 1);
    #2 reset_n = 0;
    #1;
    check("async_rst_pixel", pixel, 0);
    check("async_rst_hsync", hsync_out, 0);
    check("async_rst_vsync", vsync_out, 0);
    check("async_rst_blink", blink, 0);
    @(negedge clk);
    @(negedge clk);
    mb = 0; mcnt = 0; mprev = 0;
    reset_n = 1;
    valid_from = cyc;
    for (int h = 0; h < 12; h++) begin hpos = 9'(h); step(); end
    check("post_rst_pixel", pixel, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
